// File: rtl/atari_bus_master_if.sv
// Command/response handshake between a bus requester and atari_bus_master.
// master = requester side, slave = the bus-cycle engine.
interface atari_bus_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rw;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        cmd_halt;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;

  modport master (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata, cmd_halt,
    input  cmd_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata, cmd_halt,
    output cmd_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/atari_bus_master.sv
// Atari cartridge bus master: free-running PHI2, one command per bus cycle.
// Optional macro ATARI_BUS_HALT_EN enables per-command HALT (MARIA DMA) cycles.
module atari_bus_master #(
  parameter int PHI2_LO_CYCLES = 8,
  parameter int PHI2_HI_CYCLES = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  atari_bus_master_if.slave    host,
  output logic [15:0]          a,
  output logic                 phi2,
  output logic                 rw,
  output logic                 halt,
  output logic [7:0]           d_out,
  output logic                 d_oe,
  input  logic [7:0]           d_in
);

  localparam int         CYC_LEN = PHI2_LO_CYCLES + PHI2_HI_CYCLES;
  localparam logic [6:0] LO_C    = 7'(PHI2_LO_CYCLES);
  localparam logic [6:0] LAST_C  = 7'(CYC_LEN - 1);

  typedef enum logic {IDLE_CYC = 1'b0, XFER_CYC = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        phi2_q, phi2_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic [15:0] a_q, a_d;
  logic        rw_q, rw_d;
  logic        halt_q, halt_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  d_out_q, d_out_d;
  logic        d_oe_q, d_oe_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic        handshake_s;
  logic        xfer_s;

`ifndef ATARI_BUS_HALT_EN
  logic cmd_halt_unused_s;
  assign cmd_halt_unused_s = host.cmd_halt;
`endif

  // Phase counter, bus-cycle selection and next values of every registered output.
  always_comb begin
    cnt_d       = cnt_q;
    state_d     = state_q;
    a_d         = a_q;
    rw_d        = rw_q;
    halt_d      = halt_q;
    wdata_d     = wdata_q;
    d_out_d     = d_out_q;
    d_oe_d      = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    xfer_s      = (state_q == XFER_CYC);
    handshake_s = host.cmd_valid && cmd_ready_q;

    if (cnt_q == LAST_C) begin
      cnt_d  = 7'd0;
      // A write keeps driving for one clk past the PHI2 fall (hold time).
      d_oe_d = d_oe_q;
      if (handshake_s) begin
        state_d = XFER_CYC;
        a_d     = host.cmd_addr;
        rw_d    = host.cmd_rw;
        wdata_d = host.cmd_wdata;
`ifdef ATARI_BUS_HALT_EN
        halt_d  = ~host.cmd_halt;
`else
        halt_d  = 1'b1;
`endif
      end else begin
        state_d = IDLE_CYC;
        rw_d    = 1'b1;
        halt_d  = 1'b1;
      end
      if (xfer_s && rw_q) begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = d_in;
      end else begin
        rsp_valid_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + 7'd1;
      if ((cnt_d >= LO_C) && xfer_s && !rw_q) begin
        d_oe_d  = 1'b1;
        d_out_d = wdata_q;
      end else begin
        d_oe_d  = 1'b0;
      end
    end

    phi2_d      = (cnt_d >= LO_C);
    cmd_ready_d = (cnt_d == LAST_C);
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= 7'd0;
      state_q     <= IDLE_CYC;
      phi2_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
      a_q         <= 16'h0000;
      rw_q        <= 1'b1;
      halt_q      <= 1'b1;
      wdata_q     <= 8'h00;
      d_out_q     <= 8'h00;
      d_oe_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
    end else begin
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      phi2_q      <= phi2_d;
      cmd_ready_q <= cmd_ready_d;
      a_q         <= a_d;
      rw_q        <= rw_d;
      halt_q      <= halt_d;
      wdata_q     <= wdata_d;
      d_out_q     <= d_out_d;
      d_oe_q      <= d_oe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign host.cmd_ready = cmd_ready_q;
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_rdata = rsp_rdata_q;
  assign a              = a_q;
  assign phi2           = phi2_q;
  assign rw             = rw_q;
  assign halt           = halt_q;
  assign d_out          = d_out_q;
  assign d_oe           = d_oe_q;

endmodule
